// File: rtl/alu_pkg.sv
// alu_pkg: op codes, FSM states and op width shared by the alu_exec slice
package alu_pkg;
  localparam int ALU_OP_WIDTH = 4;
  typedef enum logic [ALU_OP_WIDTH-1:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_XOR  = 4'd3,
    OP_SLL  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8,
    OP_SRA  = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OUT  = 2'd1,
    S_MUL  = 2'd2
  } alu_state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle, low DATA_WIDTH bits of a*b (used only with ALU_MUL_EN)
module alu_mul_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [DATA_WIDTH-1:0] acc;
  // load operands on start, then add the shifted multiplicand for each set multiplier bit until the count is exhausted
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= LAST;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
    end else if (start) begin
      cnt <= '0;
      mcand <= a;
      mplier <= b;
      acc <= '0;
    end else if (cnt != LAST) begin
      acc <= mplier[0] ? acc + mcand : acc;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + CW'(1);
    end
  end
  assign done = cnt == LAST;
  assign product = acc;
endmodule

// File: rtl/alu_exec.sv
// alu_exec: registered valid/ready integer execution lane with issue tag; ALU_MUL_EN adds an iterative MUL (op 10)
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ALU_OP_WIDTH-1:0] in_op,
  input  logic [DATA_WIDTH-1:0]   in_a,
  input  logic [DATA_WIDTH-1:0]   in_b,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_result,
  output logic [TAG_WIDTH-1:0]    out_tag,
  output logic                    out_zero,
  output logic                    out_illegal
);
  localparam int SW = $clog2(DATA_WIDTH);
  alu_state_e state;
  logic accept;
  logic is_mul;
  logic [DATA_WIDTH:0] calc_r;

  function automatic logic [DATA_WIDTH:0] calc(
    input logic [ALU_OP_WIDTH-1:0] op,
    input logic [DATA_WIDTH-1:0]   a,
    input logic [DATA_WIDTH-1:0]   b
  );
    logic [SW-1:0] sh;
    logic signed [DATA_WIDTH-1:0] sa;
    logic [DATA_WIDTH-1:0] sra;
    sh = b[SW-1:0];
    sa = $signed(a);
    sra = sa >>> sh;
    case (op)
      OP_AND:  calc = {1'b0, a & b};
      OP_OR:   calc = {1'b0, a | b};
      OP_ADD:  calc = {1'b0, a + b};
      OP_XOR:  calc = {1'b0, a ^ b};
      OP_SLL:  calc = {1'b0, a << sh};
      OP_SRL:  calc = {1'b0, a >> sh};
      OP_SUB:  calc = {1'b0, a - b};
      OP_SLT:  calc = {1'b0, {(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: calc = {1'b0, {(DATA_WIDTH-1){1'b0}}, a < b};
      OP_SRA:  calc = {1'b0, sra};
      default: calc = {1'b1, {DATA_WIDTH{1'b0}}};
    endcase
  endfunction

  assign in_ready = (state == S_IDLE) || (state == S_OUT && out_ready);
  assign out_valid = state == S_OUT;
  assign accept = in_valid && in_ready;
  assign calc_r = calc(in_op, in_a, in_b);

`ifdef ALU_MUL_EN
  logic mul_done;
  logic [DATA_WIDTH-1:0] mul_product;
  logic [TAG_WIDTH-1:0] pend_tag;
  assign is_mul = in_op == OP_MUL;

  alu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start(accept && is_mul),
    .a(in_a),
    .b(in_b),
    .done(mul_done),
    .product(mul_product)
  );

  // keep the MUL tag aside so a result still being drained keeps its own tag
  always_ff @(posedge clk) begin
    if (rst) pend_tag <= '0;
    else if (accept) pend_tag <= in_tag;
  end
`else
  assign is_mul = 1'b0;
`endif

  // state machine and output register; out_* only change on accept, MUL completion or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      out_result <= '0;
      out_tag <= '0;
      out_zero <= 1'b0;
      out_illegal <= 1'b0;
    end else if (accept && !is_mul) begin
      state <= S_OUT;
      out_result <= calc_r[DATA_WIDTH-1:0];
      out_illegal <= calc_r[DATA_WIDTH];
      out_zero <= calc_r[DATA_WIDTH-1:0] == '0;
      out_tag <= in_tag;
`ifdef ALU_MUL_EN
    end else if (accept) begin
      state <= S_MUL;
    end else if (state == S_MUL && mul_done) begin
      state <= S_OUT;
      out_result <= mul_product;
      out_illegal <= 1'b0;
      out_zero <= mul_product == '0;
      out_tag <= pend_tag;
`endif
    end else if (out_valid && out_ready) begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec with directed vectors; follows ALU_MUL_EN like the design
module tb_alu_exec;
  import alu_pkg::*;
  localparam int W = 32;
  localparam int T = 6;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [3:0] in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [T-1:0] in_tag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [W-1:0] out_result;
  logic [T-1:0] out_tag;
  logic out_zero;
  logic out_illegal;

  typedef struct packed {
    logic [W-1:0] r;
    logic [T-1:0] tag;
    logic z;
    logic ill;
    logic [31:0] c;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  bit seen = 0;

  alu_exec #(.DATA_WIDTH(W), .TAG_WIDTH(T)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_zero(out_zero), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    #2;
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        if (out_ready) chk("spurious_valid", 64'(out_valid), 64'd0);
      end else begin
        if (!seen) begin
          chk("latency", 64'(cyc), 64'(q[0].c));
          seen = 1;
        end
        if (out_ready) begin
          chk("result", 64'(out_result), 64'(q[0].r));
          chk("tag", 64'(out_tag), 64'(q[0].tag));
          chk("zero", 64'(out_zero), 64'(q[0].z));
          chk("illegal", 64'(out_illegal), 64'(q[0].ill));
          void'(q.pop_front());
          seen = 0;
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [T-1:0] tag, input logic [W-1:0] r, input logic ill,
                      input bit mul, input bit need_rdy);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    in_tag = tag;
    #1;
    if (need_rdy) chk("in_ready_b2b", 64'(in_ready), 64'd1);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    q.push_back('{r, tag, r == '0, ill, 32'(cyc + 1 + (mul ? W + 1 : 0))});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    send(OP_ADD, 32'hFFFF_FFFF, 32'h1, 6'd5, 32'h0, 1'b0, 0, 1);
    drain();

    send(OP_SUB, 32'd5, 32'd7, 6'd1, 32'hFFFF_FFFE, 1'b0, 0, 1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'd1, 6'd2, 32'd1, 1'b0, 0, 1);
    send(OP_SRA, 32'h8000_0000, 32'd4, 6'd3, 32'hF800_0000, 1'b0, 0, 1);
    drain();

    @(negedge clk);
    out_ready = 1'b0;
    send(OP_SLL, 32'd1, 32'd33, 6'd7, 32'h2, 1'b0, 0, 1);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_result", 64'(out_result), 64'h2);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    send(4'd15, 32'h1234, 32'h5678, 6'd9, 32'h0, 1'b1, 0, 1);
    send(OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 6'd10, 32'h00F0_00F0, 1'b0, 0, 1);
    send(OP_OR, 32'h1234_0000, 32'h0000_5678, 6'd11, 32'h1234_5678, 1'b0, 0, 1);
    send(OP_XOR, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 6'd12, 32'h5555_5555, 1'b0, 0, 1);
    send(OP_SRL, 32'h8000_0000, 32'd63, 6'd13, 32'h1, 1'b0, 0, 1);
    send(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 6'd14, 32'h1, 1'b0, 0, 1);
    send(OP_SLT, 32'd1, 32'hFFFF_FFFF, 6'd15, 32'h0, 1'b0, 0, 1);
    drain();

`ifdef ALU_MUL_EN
    send(OP_MUL, 32'h0001_0000, 32'h0001_0001, 6'd3, 32'h0001_0000, 1'b0, 1, 1);
    bad = 0;
    for (int i = 0; i < 60 && !out_valid; i++) begin
      @(negedge clk);
      #1;
      if (!out_valid && in_ready) bad++;
    end
    chk("mul_busy_in_ready", 64'(bad), 64'd0);
    drain();

    send(OP_MUL, 32'h0001_0000, 32'h0001_0001, 6'd4, 32'h0001_0000, 1'b0, 1, 1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    q.delete();
    seen = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mul_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mul_rst_in_ready", 64'(in_ready), 64'd1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (out_valid) bad++;
    end
    chk("mul_rst_stale", 64'(bad), 64'd0);
`else
    send(4'd10, 32'h0001_0000, 32'h0001_0001, 6'd3, 32'h0, 1'b1, 0, 1);
    drain();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
